// File: rtl/fm_discrim_decim_if.sv
// Stream bus bundle for the FM discriminator: one beat per tvalid&&tready.
interface fm_discrim_decim_if #(
  parameter int TDATA_W = 32
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_W-1:0]     tdata;
  logic                   tlast;
  logic [TDATA_W/8-1:0]   tstrb;

  modport master (output tvalid, tdata, tlast, tstrb, input  tready);
  modport slave  (input  tvalid, tdata, tlast, tstrb, output tready);
endinterface

// File: rtl/fm_discrim_decim.sv
// FM discriminator with decimation: sums wrapped phase differences over
// groups of 2^DECIM_LOG2 beats (or up to tlast) and emits one output per group.
// Mode 1 passes the group-end phase, mode 2 emits a free-running group count.
module fm_discrim_decim #(
  parameter int ANGLE_W    = 16,
  parameter int DECIM_LOG2 = 2,
  parameter int TDATA_W    = 32
) (
  input  logic                      s00_axis_aclk,
  input  logic                      s00_axis_areset,
  fm_discrim_decim_if.slave         s00_axis,
  fm_discrim_decim_if.master        m00_axis,
  input  logic [1:0]                mode,
  input  logic [15:0]               squelch_thresh
);
  localparam int ACC_W = ANGLE_W + DECIM_LOG2;
  // Zero-width counter is avoided; with no decimation it stays at 0 = last.
  localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);

  if ((ANGLE_W + DECIM_LOG2 > TDATA_W) || (ANGLE_W > TDATA_W - 16)) begin : g_param_chk
    $error("fm_discrim_decim: ANGLE_W/DECIM_LOG2 do not fit in TDATA_W");
  end

  logic                     r_vld;
  logic [TDATA_W-1:0]       r_data;
  logic                     r_last;
  logic [TDATA_W/8-1:0]     r_strb;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic [ANGLE_W-1:0]       r_prev;
  logic                     r_primed;
  logic [1:0]               r_mode;
  logic [TDATA_W-1:0]       r_ramp;

  logic                     w_acc;
  logic                     w_first;
  logic                     w_gend;
  logic                     w_sq;
  logic [15:0]              w_mag;
  logic [ANGLE_W-1:0]       w_phase;
  logic [ANGLE_W-1:0]       w_diff;
  logic signed [ANGLE_W-1:0] w_d;
  logic signed [ACC_W-1:0]  w_sum;
  logic [1:0]               w_mode_in;
  logic [1:0]               w_mode;
  logic [TDATA_W-1:0]       w_res;
  logic                     w_unused;

  // Upper tdata bits beyond the phase field carry no information.
  assign w_unused = ^s00_axis.tdata;

  assign s00_axis.tready = m00_axis.tready || !r_vld;
  assign w_acc   = s00_axis.tvalid && s00_axis.tready;
  assign w_first = (r_cnt == '0);
  assign w_gend  = (r_cnt == CNT_LAST) || s00_axis.tlast;

  assign w_mag   = s00_axis.tdata[15:0];
  assign w_phase = s00_axis.tdata[15+ANGLE_W:16];
  assign w_diff  = w_phase - r_prev;
  assign w_sq    = (squelch_thresh != 16'd0) && (w_mag < squelch_thresh);
  // Unprimed or squelched beats contribute nothing but still move prev_phase.
  assign w_d     = (r_primed && !w_sq) ? signed'(w_diff) : '0;
  // Group width of ANGLE_W+DECIM_LOG2 bits holds 2^DECIM_LOG2 worst-case diffs.
  assign w_sum   = r_acc + ACC_W'(w_d);

  // Mode 3 is an alias of the discriminator; the group's mode is taken at beat 0.
  assign w_mode_in = (mode == 2'd3) ? 2'd0 : mode;
  assign w_mode    = w_first ? w_mode_in : r_mode;

  // Result mux for the group-end beat.
  always_comb begin
    w_res = TDATA_W'(w_sum);
    case (w_mode)
      2'd1:    w_res = TDATA_W'(w_phase);
      2'd2:    w_res = r_ramp;
      default: w_res = TDATA_W'(w_sum);
    endcase
  end

  // Accumulate per beat, close groups into the output register, drain on ready.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      r_vld    <= 1'b0;
      r_data   <= '0;
      r_last   <= 1'b0;
      r_strb   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_prev   <= '0;
      r_primed <= 1'b0;
      r_mode   <= 2'd0;
      r_ramp   <= '0;
    end else begin
      if (r_vld && m00_axis.tready) r_vld <= 1'b0;
      if (w_acc) begin
        r_prev   <= w_phase;
        r_primed <= 1'b1;
        if (w_first) r_mode <= w_mode_in;
        if (w_gend) begin
          // A group end loads over a simultaneous drain, so no bubble appears.
          r_vld  <= 1'b1;
          r_data <= w_res;
          r_last <= s00_axis.tlast;
          r_strb <= s00_axis.tstrb;
          r_acc  <= '0;
          r_cnt  <= '0;
          r_ramp <= r_ramp + TDATA_W'(1);
        end else begin
          r_acc  <= w_sum;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign m00_axis.tvalid = r_vld;
  assign m00_axis.tdata  = r_data;
  assign m00_axis.tlast  = r_last;
  assign m00_axis.tstrb  = r_strb;
endmodule

// File: tb/tb_fm_discrim_decim.sv
// Directed bench for fm_discrim_decim: beat table plus stall/reset/no-decim sequences.
module tb_fm_discrim_decim;
  localparam int TDATA_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [15:0] thr;
  int checks   = 0;
  int failures = 0;

  fm_discrim_decim_if #(.TDATA_W(TDATA_W)) s_if ();
  fm_discrim_decim_if #(.TDATA_W(TDATA_W)) m_if ();
  fm_discrim_decim_if #(.TDATA_W(TDATA_W)) s0_if ();
  fm_discrim_decim_if #(.TDATA_W(TDATA_W)) m0_if ();

  fm_discrim_decim #(.ANGLE_W(16), .DECIM_LOG2(2), .TDATA_W(TDATA_W)) dut (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(s_if), .m00_axis(m_if),
    .mode(mode), .squelch_thresh(thr));

  fm_discrim_decim #(.ANGLE_W(16), .DECIM_LOG2(0), .TDATA_W(TDATA_W)) dut0 (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(s0_if), .m00_axis(m0_if),
    .mode(mode), .squelch_thresh(thr));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ph;
    logic [15:0] mag;
    logic        lst;
    logic [1:0]  md;
    logic [15:0] th;
    logic        ev;
    logic [31:0] ed;
    logic        el;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [15:0] ph, input logic ev, input logic [31:0] ed,
                              input logic lst, input logic [15:0] mag, input logic [1:0] md,
                              input logic [15:0] th);
    vec_t v;
    v.ph = ph; v.mag = mag; v.lst = lst; v.md = md; v.th = th;
    v.ev = ev; v.ed = ed; v.el = lst;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One beat on the decimating DUT, sampled 1 time unit after the edge.
  task automatic beat(input logic [15:0] ph, input logic lst, input logic [3:0] strb);
    s_if.tdata  = {ph, 16'hFFFF};
    s_if.tlast  = lst;
    s_if.tstrb  = strb;
    s_if.tvalid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic beat0(input logic [15:0] ph);
    s0_if.tdata  = {ph, 16'hFFFF};
    s0_if.tvalid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    s_if.tvalid = 1'b0; s0_if.tvalid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; thr = 16'd0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tstrb = '0;
    s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tlast = 1'b0; s0_if.tstrb = '1;
    m_if.tready = 1'b1; m0_if.tready = 1'b1;

    // ---- reset state
    #12;
    chk("rst_vld",  32'(m_if.tvalid), 32'h0);
    chk("rst_data", m_if.tdata, 32'h0);
    chk("rst_last", 32'(m_if.tlast), 32'h0);
    chk("rst_strb", 32'(m_if.tstrb), 32'h0);
    chk("rst_srdy", 32'(s_if.tready), 32'h1);
    @(negedge clk); rst = 1'b0;

    // ---- table: ph, exp_vld, exp_data, tlast, mag, mode, thresh
    add(16'h0000, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'h0100, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'h0200, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'h0300, 1, 32'h0000_0300, 0, 16'hFFFF, 0, 0);
    // prime to 0xFF40 (one big negative step)
    add(16'hFF40, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'hFF40, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'hFF40, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'hFF40, 1, 32'hFFFF_FC40, 0, 16'hFFFF, 0, 0);
    // ascending across the wrap
    add(16'hFFC0, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'h0040, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'h00C0, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'h0140, 1, 32'h0000_0200, 0, 16'hFFFF, 0, 0);
    // descending across the wrap
    add(16'h00C0, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'h0040, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'hFFC0, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'hFF40, 1, 32'hFFFF_FE00, 0, 16'hFFFF, 0, 0);
    // tlast closes a 2-beat group, next group counts from 0
    add(16'hFF50, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'hFF60, 1, 32'h0000_0020, 1, 16'hFFFF, 0, 0);
    add(16'hFF70, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'hFF80, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'hFF90, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'hFFA0, 1, 32'h0000_0040, 0, 16'hFFFF, 0, 0);
    // squelch at 0x0100
    add(16'hFFB0, 0, 0, 0, 16'h00FF, 0, 16'h0100);
    add(16'hFFC0, 0, 0, 0, 16'h0100, 0, 16'h0100);
    add(16'hFFD0, 0, 0, 0, 16'hFFFF, 0, 16'h0100);
    add(16'hFFE0, 1, 32'h0000_0020, 0, 16'h0000, 0, 16'h0100);
    // mode 1 latched at beat 0, later mode 0 ignored
    add(16'h1000, 0, 0, 0, 16'hFFFF, 1, 0);
    add(16'h2000, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'h3000, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'hABCD, 1, 32'h0000_ABCD, 0, 16'hFFFF, 0, 0);
    // mode 0 latched, later mode 1 ignored
    add(16'hAC0D, 0, 0, 0, 16'hFFFF, 0, 0);
    add(16'hAC4D, 0, 0, 0, 16'hFFFF, 1, 0);
    add(16'hAC8D, 0, 0, 0, 16'hFFFF, 1, 0);
    add(16'hACCD, 1, 32'h0000_0100, 0, 16'hFFFF, 1, 0);
    // mode 3 behaves as discriminator
    add(16'hACDD, 0, 0, 0, 16'hFFFF, 3, 0);
    add(16'hACED, 0, 0, 0, 16'hFFFF, 3, 0);
    add(16'hACFD, 0, 0, 0, 16'hFFFF, 3, 0);
    add(16'hAD0D, 1, 32'h0000_0040, 0, 16'hFFFF, 3, 0);
    // mode 2: ten outputs emitted so far
    add(16'h0000, 0, 0, 0, 16'hFFFF, 2, 0);
    add(16'h1111, 0, 0, 0, 16'hFFFF, 2, 0);
    add(16'h2222, 0, 0, 0, 16'hFFFF, 2, 0);
    add(16'h3333, 1, 32'h0000_000A, 0, 16'hFFFF, 2, 0);

    foreach (tbl[i]) begin
      mode = tbl[i].md; thr = tbl[i].th;
      s_if.tdata = {tbl[i].ph, tbl[i].mag};
      s_if.tlast = tbl[i].lst; s_if.tstrb = 4'hF; s_if.tvalid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_vld", i), 32'(m_if.tvalid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_data", i), m_if.tdata, tbl[i].ed);
        chk($sformatf("vec%0d_last", i), 32'(m_if.tlast), 32'(tbl[i].el));
        chk($sformatf("vec%0d_strb", i), 32'(m_if.tstrb), 32'hF);
      end
    end
    s_if.tvalid = 1'b0; mode = 2'd0; thr = 16'd0;

    // ---- backpressure: 5-cycle stall, then drain + 1-beat group end together
    do_reset;
    m_if.tready = 1'b0;
    beat(16'h0100, 0, 4'hF); beat(16'h0110, 0, 4'hF);
    beat(16'h0120, 0, 4'hF); beat(16'h0130, 0, 4'hF);
    chk("bp_vld0",  32'(m_if.tvalid), 32'h1);
    chk("bp_data0", m_if.tdata, 32'h0000_0030);
    s_if.tdata = {16'h0170, 16'hFFFF}; s_if.tlast = 1'b1; s_if.tstrb = 4'h5;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_vld", k),  32'(m_if.tvalid), 32'h1);
      chk($sformatf("stall%0d_data", k), m_if.tdata, 32'h0000_0030);
      chk($sformatf("stall%0d_srdy", k), 32'(s_if.tready), 32'h0);
    end
    m_if.tready = 1'b1; #1;
    chk("bp_srdy_rel", 32'(s_if.tready), 32'h1);
    @(posedge clk); #1;
    chk("b2b_vld",  32'(m_if.tvalid), 32'h1);
    chk("b2b_data", m_if.tdata, 32'h0000_0040);
    chk("b2b_last", 32'(m_if.tlast), 32'h1);
    chk("b2b_strb", 32'(m_if.tstrb), 32'h5);
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    @(posedge clk); #1;
    chk("drain_vld", 32'(m_if.tvalid), 32'h0);

    // ---- mode 2 ramp, reset mid-group, ramp restart, mode change mid-group
    do_reset;
    mode = 2'd2;
    for (int g = 0; g < 3; g++) begin
      for (int b = 0; b < 4; b++)
        beat(16'h0000, (g == 2 && b == 3), (g == 2 && b == 3) ? 4'hA : 4'hF);
      chk($sformatf("ramp%0d", g), m_if.tdata, 32'(g));
    end
    chk("ramp_last", 32'(m_if.tlast), 32'h1);
    beat(16'h0000, 0, 4'hF); beat(16'h0000, 0, 4'hF);
    s_if.tvalid = 1'b0;
    #2 rst = 1'b1; #1;
    chk("arst_vld",  32'(m_if.tvalid), 32'h0);
    chk("arst_data", m_if.tdata, 32'h0);
    chk("arst_last", 32'(m_if.tlast), 32'h0);
    chk("arst_strb", 32'(m_if.tstrb), 32'h0);
    @(negedge clk); rst = 1'b0;
    mode = 2'd2; beat(16'h0000, 0, 4'hF);
    mode = 2'd0; beat(16'h0010, 0, 4'hF);
    chk("restart_grp_open", 32'(m_if.tvalid), 32'h0);
    beat(16'h0020, 0, 4'hF); beat(16'h0030, 0, 4'hF);
    chk("restart_vld",  32'(m_if.tvalid), 32'h1);
    chk("restart_ramp", m_if.tdata, 32'h0);
    beat(16'h0040, 0, 4'hF); beat(16'h0050, 0, 4'hF);
    beat(16'h0060, 0, 4'hF); beat(16'h0070, 0, 4'hF);
    chk("next_grp_mode0", m_if.tdata, 32'h0000_0040);
    s_if.tvalid = 1'b0;

    // ---- no decimation: every beat is a group end
    do_reset;
    mode = 2'd0;
    beat0(16'h0010);
    chk("nd0_vld",  32'(m0_if.tvalid), 32'h1);
    chk("nd0_data", m0_if.tdata, 32'h0);
    beat0(16'h0030);
    chk("nd1_data", m0_if.tdata, 32'h0000_0020);
    beat0(16'h0020);
    chk("nd2_data", m0_if.tdata, 32'hFFFF_FFF0);
    mode = 2'd2; beat0(16'h0020);
    chk("nd3_ramp", m0_if.tdata, 32'h0000_0003);
    s0_if.tvalid = 1'b0;
    @(posedge clk); #1;
    chk("nd_drain", 32'(m0_if.tvalid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fm_discrim_decim.md
FM_DISCRIM_DECIM -- requirements
Module: fm_discrim_decim

Interface
REQ-001 SHALL have parameter ANGLE_W, default 16: width of the input phase field.
REQ-002 SHALL have parameter DECIM_LOG2, default 2: the decimation factor is 2^DECIM_LOG2; 0 means no decimation.
REQ-003 SHALL have parameter TDATA_W, default 32: width of both the s00 and m00 tdata ports; ANGLE_W+DECIM_LOG2 <= TDATA_W and ANGLE_W <= TDATA_W-16 SHALL be asserted at elaboration.
REQ-004 SHALL have port s00_axis_aclk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port s00_axis_areset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have s00 data ports: s00_axis_tvalid in 1; s00_axis_tready out 1; s00_axis_tdata in TDATA_W, where [15:0] is unsigned magnitude and [15+ANGLE_W:16] is phase (full scale = 2*pi); s00_axis_tlast in 1; s00_axis_tstrb in TDATA_W/8.
REQ-007 SHALL have m00 data ports: m00_axis_tvalid out 1; m00_axis_tready in 1; m00_axis_tdata out TDATA_W; m00_axis_tlast out 1; m00_axis_tstrb out TDATA_W/8.
REQ-008 SHALL have control inputs: mode in 2, where 0 = discriminator, 1 = raw phase, 2 = test ramp, 3 = treated as 0; squelch_thresh in 16, unsigned.

Function
REQ-009 A beat SHALL be accepted on any cycle where s00_axis_tvalid && s00_axis_tready.
REQ-010 s00_axis_tready SHALL equal m00_axis_tready || !m00_axis_tvalid, combinationally.
REQ-011 Per-beat phase difference: d = (phase - prev_phase) mod 2^ANGLE_W, read as two's-complement signed; example with ANGLE_W=16: 0x0010 - 0xFFF0 = +0x0020, 0xFFF0 - 0x0010 = -0x0020.
REQ-012 prev_phase SHALL update to phase on every accepted beat, regardless of mode or squelch.
REQ-013 The first accepted beat after reset SHALL contribute d = 0, using a primed flag cleared by reset.
REQ-014 Squelch: when magnitude < squelch_thresh, the beat SHALL contribute d = 0; squelch_thresh = 0 disables squelch.
REQ-015 The accumulator SHALL be signed, ANGLE_W+DECIM_LOG2 bits wide, and SHALL never overflow.
REQ-016 The beat counter SHALL be DECIM_LOG2 bits wide; a group ends on the beat where the counter = 2^DECIM_LOG2-1, or on any accepted beat with s00_axis_tlast = 1.
REQ-017 Group-end beat SHALL load the output register in the same edge: m00_axis_tvalid<=1, tdata<=result, tlast<=that beat's s00_axis_tlast, tstrb<=that beat's s00_axis_tstrb. Latency is 1 cycle from the group-end accept to valid output.
REQ-018 On a group end, the accumulator SHALL reset to 0 and the counter to 0 on the same edge.
REQ-019 Non-group-end beats SHALL NOT touch the output register.
REQ-020 Mode 0 result: the sum of the group's d values including the current beat, sign-extended to TDATA_W.
REQ-021 A partial group closed by tlast SHALL output its unscaled partial sum.
REQ-022 Mode 1 result: the phase of the group-end beat, zero-extended to TDATA_W.
REQ-023 Mode 2 result: a TDATA_W-bit free-running group counter, starting at 0 after reset, incrementing once per emitted output and wrapping at 2^TDATA_W.
REQ-024 mode SHALL be latched at the first beat of each group and held constant for the group; changes mid-group take effect at the next group.
REQ-025 m00_axis_tvalid SHALL fall when m00_axis_tvalid && m00_axis_tready and no group end is accepted that cycle.
REQ-026 Simultaneous drain and new group end SHALL keep valid at 1 and load new data, with no bubble.
REQ-027 While m00_axis_tvalid && !m00_axis_tready, the output register SHALL hold stable and no input SHALL be accepted.
REQ-028 With DECIM_LOG2 = 0, every accepted beat SHALL be a group end.

Reset
REQ-029 Asserting s00_axis_areset at any time, including mid-group or mid-stall, SHALL asynchronously clear: m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast, m00_axis_tstrb, accumulator, counter, prev_phase, primed flag, latched mode and ramp counter, all to 0.
REQ-030 The first group after reset deassertion SHALL start at beat 0; partial groups in progress at reset SHALL be discarded.

Verification
REQ-031 Defaults, mode 0, sink always ready, phases 0x0000, 0x0100, 0x0200, 0x0300 with magnitude 0xFFFF -> one output 0x00000300 one cycle after the 4th accept.
REQ-032 Wrap: phases 0xFFC0, 0x0040, 0x00C0, 0x0140 fed after priming -> each d = +0x0080; also a descending sequence -> negative sum sign-extended, e.g. 0xFFFFFE00.
REQ-033 tlast on the 2nd beat of a group with d = 0x10 each -> output 0x00000020 with tlast = 1; the next group restarts its count at 0.
REQ-034 squelch_thresh = 0x0100 with magnitudes 0x00FF, 0x0100 -> the 1st beat contributes 0 while prev_phase still updates; the 2nd beat contributes normally.
REQ-035 m00_axis_tready held 0 for 5 cycles with output valid -> tdata stable and s00_axis_tready = 0; on release, the drain and the next group end in the same cycle produce back-to-back outputs.
REQ-036 Reset asserted mid-group in mode 2 after 3 outputs -> all outputs 0 immediately; the ramp restarts at 0; a mode change mid-group applies only from the next group.
